// File: rtl/argo_chan_fifo_if.sv
// Channel bus between the compiler-generated producer/consumer FSMs and argo_chan_fifo.
// Optional build macro: ARGO_FIFO_ERRFLAG_EN adds the sticky overflow/underflow signals.
interface argo_chan_fifo_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic [15:0]           fifo_id;
`ifdef ARGO_FIFO_ERRFLAG_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, fifo_id
`ifdef ARGO_FIFO_ERRFLAG_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, fifo_id
`ifdef ARGO_FIFO_ERRFLAG_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/argo_chan_fifo.sv
// Guarded channel FIFO with registered read data, occupancy count, thresholds and flush.
// Optional build macro: ARGO_FIFO_ERRFLAG_EN (sticky overflow/underflow flags).
module argo_chan_fifo #(
  parameter int          ADDR_WIDTH = 3,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 1 << ADDR_WIDTH,
  parameter int          AF_LEVEL   = DEPTH - 1,
  parameter int          AE_LEVEL   = 1,
  parameter logic [15:0] FIFO_ID    = 16'd7
) (
  input  logic           clock,
  input  logic           resetn,
  argo_chan_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("argo_chan_fifo: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [15:0]           fifo_id_q;
  logic                  full, empty, rd_acc, wr_acc, mem_we;

  always_comb begin
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    rd_acc     = bus.rd_en && !empty;
    // At full a same-cycle read frees the slot the write lands in.
    wr_acc     = bus.wr_en && (!full || bus.rd_en);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    if (bus.clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_data_d  = mem_q[rptr_q];
        rptr_d     = rptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      fifo_id_q  <= FIFO_ID;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we && resetn) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = int'(count_q) >= AF_LEVEL;
  assign bus.almost_empty = int'(count_q) <= AE_LEVEL;
  assign bus.fifo_id      = fifo_id_q;

`ifdef ARGO_FIFO_ERRFLAG_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en && full && !bus.rd_en);
    underflow_d = underflow_q | (bus.rd_en && empty);
    if (bus.clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: doc/argo_chan_fifo.md
# argo_chan_fifo

Parametrised channel FIFO, the next-generation buffer behind every Argo channel. Compared with the first-generation queue it adds:
- full at exactly DEPTH entries;
- guarded reads and writes (rejected accesses leave no trace);
- simultaneous read/write at full;
- registered read data with a valid strobe;
- programmable almost-full/almost-empty thresholds, an occupancy count and a synchronous flush.

It sits between a producer and a consumer state machine generated by the compiler, one instance per channel.

## Interface
- ADDR_WIDTH, 3: address bits; depth is a power of two.
- DATA_WIDTH, 32: payload width.
- DEPTH, 1<<ADDR_WIDTH: entries. Must equal 2**ADDR_WIDTH.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL.
- FIFO_ID, 7: 16-bit instance identifier, exposed on fifo_id.

Ports:
- clock  in  1  single clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush; empties the FIFO without touching storage.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read payload.
- rd_valid  out  1  rd_data holds a newly accepted read this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- fifo_id  out  16  constant FIFO_ID after reset.

## Operation
- Storage is an internal DEPTH x DATA_WIDTH register array indexed by write_ptr/read_ptr (ADDR_WIDTH bits).
- Pointers wrap naturally modulo DEPTH.
- Read acceptance:
  - rd_acc = rd_en && !empty.
  - A rejected read changes nothing and produces no rd_valid.
- Write acceptance:
  - wr_acc = wr_en && (!full || rd_en).
  - When full, a simultaneous read frees the slot, so both are accepted.
  - A rejected write is dropped silently.
- When empty, a simultaneous rd_en/wr_en accepts only the write. There is no bypass path.
- On wr_acc: mem[write_ptr] <= wr_data; write_ptr++.
- On rd_acc: rd_data <= mem[read_ptr]; read_ptr++; rd_valid <= 1.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- clear:
  - Sets read_ptr, write_ptr and count to 0 and rd_valid to 0.
  - Overrides any wr_en/rd_en in the same cycle; those accesses are discarded.
  - rd_data holds its value.
- Reset (resetn==0 at posedge):
  - Pointers, count, rd_valid and rd_data are 0; fifo_id loads FIFO_ID.
  - Outputs after reset: empty=1, full=0, almost_empty=1 (for AE_LEVEL>=0), almost_full=0.
  - Reset mid-stream discards all contents. Storage contents are not cleared and are don't-care.
- Flags are combinational decodes of registered count, so they are valid the cycle after the count update.

## Timing
- Write-to-visible latency: data written at edge N can be read by rd_en sampled at edge N+1. empty deasserts after edge N.
- Read latency: rd_en sampled at edge N produces rd_data/rd_valid valid after edge N (one cycle). rd_valid is a single-cycle pulse per accepted read.
- Back-to-back reads every cycle sustain one word per cycle. The same applies to writes.
- Full throughput at full: continuous rd_en=wr_en=1 keeps count=DEPTH indefinitely.
- The thresholds and count never exceed DEPTH. Underflow and overflow are structurally impossible.

## Configuration
- Macro ARGO_FIFO_ERRFLAG_EN.
- Defined:
  - Adds sticky outputs overflow (wr_en while full and !rd_en) and underflow (rd_en while empty).
  - Each flag sets on the first offending cycle, holds until reset or clear, and is 0 after reset.
- Undefined: the ports are absent and no extra logic is built.
- Acceptance behaviour is identical in both builds.

## Test plan
- Reset then fill: resetn low 2 cycles, then write 0x11..0x18 on consecutive cycles.
  - Response: count steps 1..8; full=1 after the 8th write; almost_full=1 from count 7.
- Drain order: read 8 times after the fill.
  - Response: rd_valid pulses 8 times with rd_data 0x11..0x18 in order; empty=1 and count=0 at the end.
- Overflow drop: with the FIFO full, wr_en=1, wr_data=0xFF, rd_en=0.
  - Response: count stays 8 and subsequent reads never return 0xFF.
  - With ARGO_FIFO_ERRFLAG_EN: overflow=1.
- Simultaneous at boundaries:
  - Full, rd_en=wr_en=1 with 0xAA: rd_data=0x11, count stays 8, and 0xAA emerges as the 8th later read.
  - Empty, both high: only the write is accepted, count=1, no rd_valid.
- Wrap-around: 20 write/read pairs, interleaved with random gaps.
  - Response: pointers wrap past 7, data order is preserved, and count never exceeds 8.
- clear mid-stream: 5 entries, then clear=1 with wr_en=1.
  - Response: next cycle count=0, empty=1, the write is discarded, and rd_en is rejected.
  - The subsequent write of 0x42 reads back as 0x42.
